// File: rtl/fm_pkg.sv
// Shared constants, cosine table generator and quadrant folding
// for the NCO-based FM modulator.
package fm_pkg;

  localparam int PHASE_W   = 32;
  localparam int LUT_IDX_W = 12;
  localparam int QTR_AW    = 10;
  localparam int QTR_N     = 1 << QTR_AW;
  localparam int AMP       = 127;
  localparam int AMP_W     = 7;

  localparam int     FX    = 28;
  localparam longint PI_FX = 64'sd843314857;

  typedef struct packed {
    logic [QTR_AW:0] addr;
    logic            neg;
  } fold_t;

  // round(AMP*cos(2*pi*k/4096)), elaboration-time Taylor series
  function automatic logic [AMP_W-1:0] qtr_val(
    input int k
  );
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint v;
    if (k >= QTR_N) return '0;
    x    = (longint'(k) * PI_FX) / 64'sd2048;
    x2   = (x * x) >>> FX;
    term = 64'sd1 << FX;
    acc  = term;
    for (int n = 1; n <= 10; n++) begin
      term = -(((term * x2) >>> FX)
             / longint'((2*n-1) * (2*n)));
      acc  = acc + term;
    end
    v = (acc * longint'(AMP)
        + (64'sd1 << (FX-1))) >>> FX;
    return v[AMP_W-1:0];
  endfunction

  function automatic fold_t cos_fold(
    input logic [LUT_IDX_W-1:0] idx
  );
    fold_t           f;
    logic [QTR_AW:0] k;
    logic [QTR_AW:0] kr;
    k  = {1'b0, idx[QTR_AW-1:0]};
    kr = (QTR_AW+1)'(QTR_N) - k;
    f  = '0;
    unique case (idx[LUT_IDX_W-1 -: 2])
      2'd0: begin f.addr = k;  f.neg = 1'b0; end
      2'd1: begin f.addr = kr; f.neg = 1'b1; end
      2'd2: begin f.addr = k;  f.neg = 1'b1; end
      2'd3: begin f.addr = kr; f.neg = 1'b0; end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fm_cos_lut.sv
// Registered quarter-wave cosine lookup with enable hold.
// Output spans +-AMP; -128 never appears.
module fm_cos_lut
  import fm_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [LUT_IDX_W-1:0]       idx,
  output logic signed [OUT_W-1:0]    cos_out
);

  logic [AMP_W-1:0] qtab [0:QTR_N];

  for (genvar k = 0; k <= QTR_N; k++) begin : g_q
    assign qtab[k] = qtr_val(k);
  end

  fold_t                   f;
  logic [AMP_W-1:0]        mag;
  logic signed [OUT_W-1:0] val;

  always_comb begin
    f   = cos_fold(idx);
    mag = qtab[f.addr];
    val = OUT_W'({1'b0, mag});
    if (f.neg) val = -val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cos_out <= '0;
    end else if (en) begin
      cos_out <= val;
    end
  end

endmodule

// File: rtl/fm_modulator.sv
// NCO-based FM modulator: sample hold, deviation scale and clamp,
// phase accumulation, cosine lookup and output-valid fill tracking.
module fm_modulator
  import fm_pkg::*;
#(
  parameter int BB_W   = 16,
  parameter int KDEV_W = 24,
  parameter int SHIFT  = 15,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     phase_clr,
  input  logic [PHASE_W-1:0]       phi_inc,
  input  logic [KDEV_W-1:0]        kdev,
  input  logic signed [BB_W-1:0]   bb_in,
  input  logic                     bb_valid,
  output logic                     bb_ready,
  output logic signed [OUT_W-1:0]  fm_out,
  output logic                     fm_valid,
  output logic [PHASE_W-1:0]       freq_word,
  output logic [PHASE_W-1:0]       phase,
  output logic                     sat_flag
);

  localparam int PROD_W = BB_W + KDEV_W + 1;
  localparam int WIDE_W =
    (PROD_W > PHASE_W) ? PROD_W : PHASE_W;
  localparam int SUM_W  = WIDE_W + 1;

  localparam logic [PHASE_W-1:0] FW_MAX =
    {1'b0, {(PHASE_W-1){1'b1}}};

  logic signed [BB_W-1:0]   bb_reg;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] dev;
  logic signed [SUM_W-1:0]  sum;
  logic                     clamp_lo;
  logic                     clamp_hi;
  logic [PHASE_W-1:0]       fw_next;
  logic [1:0]               fill;

  // S0: sample-and-hold of the baseband input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bb_ready <= 1'b0;
      bb_reg   <= '0;
    end else begin
      bb_ready <= en;
      if (bb_valid && bb_ready) bb_reg <= bb_in;
    end
  end

  // S1: floor-shifted deviation plus carrier, clamped to [0, 2^31-1]
  always_comb begin
    prod     = bb_reg * $signed({1'b0, kdev});
    dev      = prod >>> SHIFT;
    sum      = $signed({{(SUM_W-PROD_W){dev[PROD_W-1]}}, dev})
             + $signed({{(SUM_W-PHASE_W){1'b0}}, phi_inc});
    clamp_lo = sum[SUM_W-1];
    clamp_hi = !sum[SUM_W-1] && (|sum[SUM_W-2:PHASE_W-1]);
    fw_next  = sum[PHASE_W-1:0];
    if (clamp_lo) fw_next = '0;
    if (clamp_hi) fw_next = FW_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      freq_word <= '0;
      sat_flag  <= 1'b0;
    end else if (en) begin
      freq_word <= fw_next;
      if (clamp_lo || clamp_hi) sat_flag <= 1'b1;
    end
  end

  // S2: phase accumulator; clear wins over enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (phase_clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + freq_word;
    end
  end

  // S3: cosine of the top phase bits
  fm_cos_lut #(
    .OUT_W (OUT_W)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .idx     (phase[PHASE_W-1 -: LUT_IDX_W]),
    .cos_out (fm_out)
  );

  // output is valid once three consecutive enabled cycles fill S1..S3
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill     <= '0;
      fm_valid <= 1'b0;
    end else if (!en) begin
      fill     <= '0;
      fm_valid <= 1'b0;
    end else begin
      if (fill != 2'd3) fill <= fill + 2'd1;
      fm_valid <= (fill >= 2'd2);
    end
  end

endmodule
